// File: rtl/med_alarm_queue_if.sv
// Scheduler/user-facing bus of the medication alarm queue.
// The slave side is the queue itself; the master side drives due doses and the ack button.
interface med_alarm_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic          due_valid;
  logic [3:0]    due_idx;
  logic [7:0]    due_time;
  logic          ack;

  logic          alarm_active;
  logic          buzzer;
  logic [3:0]    cur_idx;
  logic [7:0]    cur_time;
  logic [PW-1:0] pending;
  logic [7:0]    taken_cnt;
  logic [7:0]    missed_cnt;
  logic          overflow;
  logic          log_valid;
  logic          log_taken;
  logic [3:0]    log_idx;
  logic [7:0]    log_time;

  modport master (
    output due_valid, due_idx, due_time, ack,
    input  alarm_active, buzzer, cur_idx, cur_time, pending,
           taken_cnt, missed_cnt, overflow,
           log_valid, log_taken, log_idx, log_time
  );

  modport slave (
    input  due_valid, due_idx, due_time, ack,
    output alarm_active, buzzer, cur_idx, cur_time, pending,
           taken_cnt, missed_cnt, overflow,
           log_valid, log_taken, log_idx, log_time
  );
endinterface

// File: rtl/med_alarm_queue.sv
// Medication alarm queue: buffers due doses, rings one at a time until acknowledged
// or timed out, then reports the outcome to the logger and the taken/missed counters.
module med_alarm_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned BEEP_HALF = 8
) (
  input  logic            clk,
  input  logic            rst,
  med_alarm_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam int unsigned EW = 12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RING = 2'd1;
  localparam logic [1:0] S_LOG  = 2'd2;

  // FIFO storage and pointers
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] count_q;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          ack_prev_q;

  logic          alarm_q, alarm_d;
  logic          buzzer_q, buzzer_d;
  logic [3:0]    cur_idx_q, cur_idx_d;
  logic [7:0]    cur_time_q, cur_time_d;
  logic [7:0]    taken_q, taken_d;
  logic [7:0]    missed_q, missed_d;
  logic          overflow_q, overflow_d;
  logic          log_valid_q, log_valid_d;
  logic          log_taken_q, log_taken_d;
  logic [3:0]    log_idx_q, log_idx_d;
  logic [7:0]    log_time_q, log_time_d;

  logic          full_c, empty_c, pop_c, push_c, drop_c;
  logic          ack_edge_c, timeout_c, missed_inc_c;
  logic [8:0]    missed_sum_c;
  logic [EW-1:0] head_c;

  assign full_c     = (count_q == PW'(DEPTH));
  assign empty_c    = (count_q == '0);
  assign pop_c      = (state_q == S_IDLE) && !empty_c;
  assign push_c     = bus.due_valid && (!full_c || pop_c);
  assign drop_c     = bus.due_valid && full_c && !pop_c;
  assign ack_edge_c = bus.ack && !ack_prev_q;
  assign timeout_c  = (timer_q == TW'(TIMEOUT - 1));
  assign head_c     = mem[rd_ptr_q];

  // FIFO payload array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= {bus.due_idx, bus.due_time};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    beep_cnt_d   = beep_cnt_q;
    alarm_d      = alarm_q;
    buzzer_d     = buzzer_q;
    cur_idx_d    = cur_idx_q;
    cur_time_d   = cur_time_q;
    taken_d      = taken_q;
    log_valid_d  = 1'b0;
    log_taken_d  = log_taken_q;
    log_idx_d    = log_idx_q;
    log_time_d   = log_time_q;
    missed_inc_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        alarm_d  = 1'b0;
        buzzer_d = 1'b0;
        if (pop_c) begin
          cur_idx_d  = head_c[11:8];
          cur_time_d = head_c[7:0];
          timer_d    = '0;
          beep_cnt_d = '0;
          alarm_d    = 1'b1;
          buzzer_d   = 1'b1;
          state_d    = S_RING;
        end
      end
      S_RING: begin
        // An ack edge takes priority over a coincident timeout
        if (ack_edge_c || timeout_c) begin
          state_d     = S_LOG;
          alarm_d     = 1'b0;
          buzzer_d    = 1'b0;
          log_valid_d = 1'b1;
          log_taken_d = ack_edge_c;
          log_idx_d   = cur_idx_q;
          log_time_d  = cur_time_q;
        end else begin
          timer_d = timer_q + TW'(1);
          if (beep_cnt_q == BW'(BEEP_HALF - 1)) begin
            beep_cnt_d = '0;
            buzzer_d   = ~buzzer_q;
          end else begin
            beep_cnt_d = beep_cnt_q + BW'(1);
          end
        end
      end
      S_LOG: begin
        state_d = S_IDLE;
        if (log_taken_q) begin
          taken_d = (taken_q == 8'hFF) ? 8'hFF : taken_q + 8'd1;
        end else begin
          missed_inc_c = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        alarm_d  = 1'b0;
        buzzer_d = 1'b0;
      end
    endcase
  end

  // A timeout resolution and a FIFO drop may land together: add both, saturate once
  assign missed_sum_c = 9'(missed_q) + 9'(missed_inc_c) + 9'(drop_c);
  assign missed_d     = (missed_sum_c > 9'd255) ? 8'hFF : missed_sum_c[7:0];
  assign overflow_d   = overflow_q | drop_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      beep_cnt_q  <= '0;
      ack_prev_q  <= 1'b0;
      alarm_q     <= 1'b0;
      buzzer_q    <= 1'b0;
      cur_idx_q   <= '0;
      cur_time_q  <= '0;
      taken_q     <= '0;
      missed_q    <= '0;
      overflow_q  <= 1'b0;
      log_valid_q <= 1'b0;
      log_taken_q <= 1'b0;
      log_idx_q   <= '0;
      log_time_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      beep_cnt_q  <= beep_cnt_d;
      ack_prev_q  <= bus.ack;
      alarm_q     <= alarm_d;
      buzzer_q    <= buzzer_d;
      cur_idx_q   <= cur_idx_d;
      cur_time_q  <= cur_time_d;
      taken_q     <= taken_d;
      missed_q    <= missed_d;
      overflow_q  <= overflow_d;
      log_valid_q <= log_valid_d;
      log_taken_q <= log_taken_d;
      log_idx_q   <= log_idx_d;
      log_time_q  <= log_time_d;
    end
  end

  assign bus.alarm_active = alarm_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.cur_idx      = cur_idx_q;
  assign bus.cur_time     = cur_time_q;
  assign bus.pending      = count_q;
  assign bus.taken_cnt    = taken_q;
  assign bus.missed_cnt   = missed_q;
  assign bus.overflow     = overflow_q;
  assign bus.log_valid    = log_valid_q;
  assign bus.log_taken    = log_taken_q;
  assign bus.log_idx      = log_idx_q;
  assign bus.log_time     = log_time_q;

endmodule

// File: doc/med_alarm_queue.md
MED_ALARM_QUEUE -- requirements
Module: med_alarm_queue

Interface
REQ-001 Parameter DEPTH, default 4, gives the number of pending-alarm FIFO entries (power of two, 2..8).
REQ-002 Parameter TIMEOUT, default 200, gives the number of RING cycles before an unacknowledged dose is declared missed (>=2).
REQ-003 Parameter BEEP_HALF, default 8, gives the number of cycles per buzzer half-period (>=1).
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port due_valid, input, 1 bit: one-cycle strobe from the scheduler meaning a dose is due.
REQ-007 Port due_idx, input, 4 bits: medication index of the due dose.
REQ-008 Port due_time, input, 8 bits: internal-clock time of the due dose.
REQ-009 Port ack, input, 1 bit: user acknowledge button, level, already synchronised.
REQ-010 Port alarm_active, output, 1 bit: high while an alarm is ringing.
REQ-011 Port buzzer, output, 1 bit: square-wave buzzer drive.
REQ-012 Port cur_idx, output, 4 bits: index of the dose currently ringing.
REQ-013 Port cur_time, output, 8 bits: time of the dose currently ringing.
REQ-014 Port pending, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 Port taken_cnt, output, 8 bits: acknowledged doses, saturating at 255.
REQ-016 Port missed_cnt, output, 8 bits: timed-out plus dropped doses, saturating at 255.
REQ-017 Port overflow, output, 1 bit: sticky flag set when a due dose was dropped.
REQ-018 Port log_valid, output, 1 bit: one-cycle strobe to the logger.
REQ-019 Port log_taken, output, 1 bit: 1 means acknowledged, 0 means missed; valid with log_valid.
REQ-020 Port log_idx, output, 4 bits; log_time, output, 8 bits: the resolved dose; valid with log_valid.

Function
REQ-021 The FIFO SHALL push {due_idx, due_time} on every cycle with due_valid=1 unless it is full.
REQ-022 A push while full and not simultaneously popped SHALL be dropped, SHALL set overflow, and SHALL increment missed_cnt by 1.
REQ-023 A simultaneous push and pop on a full FIFO SHALL accept the push, leaving pending unchanged.
REQ-024 The FSM SHALL have three states:
- IDLE: alarm_active=0, buzzer=0.
- RING: alarm_active=1.
- LOG: one cycle only.
REQ-025 In IDLE with pending>0, the FSM SHALL pop the head into cur_idx/cur_time, clear the timer, and enter RING on the next edge.
REQ-026 A due_valid into an empty FIFO in IDLE SHALL produce alarm_active=1 on the second cycle after the due_valid cycle.
REQ-027 In RING, the timer SHALL count cycles from 0, and buzzer SHALL be 1 for BEEP_HALF cycles then 0 for BEEP_HALF cycles, repeating, starting high on the first RING cycle.
REQ-028 A rising edge of ack (ack=1 with previous-cycle ack=0) detected in RING SHALL move the FSM to LOG with log_taken=1.
REQ-029 If the timer equals TIMEOUT-1 in RING with no ack edge, the FSM SHALL move to LOG with log_taken=0.
REQ-030 If an ack edge and the timeout occur in the same cycle, the ack edge SHALL win.
REQ-031 The ack-previous register SHALL update every cycle in all states.
REQ-032 Ack edges outside RING SHALL be ignored; ack held high into RING SHALL NOT count as an edge.
REQ-033 In LOG, the block SHALL:
- assert log_valid for exactly one cycle, with log_idx/log_time equal to cur_idx/cur_time;
- increment taken_cnt or missed_cnt, saturating;
- return to IDLE.
REQ-034 If a LOG-missed and a FIFO drop occur in the same cycle, missed_cnt SHALL increase by 2, saturating at 255.
REQ-035 cur_idx/cur_time SHALL hold their last value while in IDLE.

Reset
REQ-036 While rst=1 at a clock edge, the block SHALL reset:
- FSM to IDLE; FIFO to empty; timer and ack-previous to 0.
- Outputs alarm_active, buzzer, cur_idx, cur_time, pending, taken_cnt, missed_cnt, overflow, log_valid, log_taken, log_idx, log_time all to 0.
REQ-037 A reset asserted during RING or LOG SHALL discard the in-flight dose and emit no log_valid.

Verification
REQ-038 due_valid with idx=3, time=0x2A, then ack rising 20 cycles later -> alarm_active high 2 cycles after due_valid; log_valid for one cycle with taken=1, idx=3, time=0x2A; taken_cnt=1.
REQ-039 Single due with no ack (TIMEOUT=200) -> alarm_active high for exactly 200 cycles; log_taken=0; missed_cnt=1; buzzer toggles every 8 cycles.
REQ-040 Six due_valid strobes on consecutive cycles with DEPTH=4 and no ack -> pending peaks at 4; overflow=1; missed_cnt counts drops plus timeouts; log order matches push order.
REQ-041 Ack held high from before RING entry, released, then re-pressed at RING cycle 50 -> no log until cycle 50; then taken=1.
REQ-042 Ack edge on the timeout cycle -> log_taken=1.
REQ-043 rst pulsed at RING cycle 10 -> all outputs 0 next cycle; no log_valid.
REQ-044 300 acknowledged doses -> taken_cnt saturates at 255.
